// File: rtl/hyperbus_ram_responder_if.sv
// Request/response signal bundle between a HyperBus-style requester and the RAM responder.
// The master drives the request side; the slave returns ready, read data, the valid pulse and the error pulse.
interface hyperbus_ram_responder_if #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16
);
    logic [HBUS_ADDR_WIDTH-1:0]   hbus_adr_i;
    logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_i;
    logic [HBUS_DATA_WIDTH/8-1:0] hbus_mask_i;
    logic                         hbus_rrq;
    logic                         hbus_wrq;
    logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_o;
    logic                         hbus_ready;
    logic                         hbus_valid;
    logic                         hbus_err;

    modport master (
        output hbus_adr_i, hbus_dat_i, hbus_mask_i, hbus_rrq, hbus_wrq,
        input  hbus_dat_o, hbus_ready, hbus_valid, hbus_err
    );

    modport slave (
        input  hbus_adr_i, hbus_dat_i, hbus_mask_i, hbus_rrq, hbus_wrq,
        output hbus_dat_o, hbus_ready, hbus_valid, hbus_err
    );
endinterface

// File: rtl/hyperbus_ram_responder.sv
// Single-outstanding RAM responder: accepts one read/write, answers LATENCY+1 edges after acceptance.
// Requests are accepted only while hbus_ready=1; requests seen while busy are dropped, not queued.
module hyperbus_ram_responder #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int DEPTH           = 1024,
    parameter int LATENCY         = 4
) (
    input  logic                     hbus_clk,
    input  logic                     hbus_rst,
    hyperbus_ram_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = HBUS_DATA_WIDTH / 8;
    localparam logic [HBUS_ADDR_WIDTH-1:0] DEPTH_W  = HBUS_ADDR_WIDTH'(DEPTH);
    localparam logic [7:0]                 LAT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, LAT, RESP} state_t;

    // Address bit 0 selects a byte within a halfword and never matters, so it is not kept.
    typedef struct packed {
        logic [HBUS_ADDR_WIDTH-2:0] wadr;
        logic [HBUS_DATA_WIDTH-1:0] dat;
        logic [NB-1:0]              mask;
        logic                       wr;
    } req_t;

    state_t                     state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d;
    req_t                       req_q, req_d;
    logic                       ready_q, ready_d;
    logic                       valid_q, valid_d;
    logic                       err_q, err_d;
    logic [HBUS_DATA_WIDTH-1:0] dat_o_q, dat_o_d;

    logic [HBUS_DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]           widx;
    logic                       oor;
    logic                       mem_we;
    logic [HBUS_DATA_WIDTH-1:0] wr_word;

    assign widx = req_q.wadr[IDX_W-1:0];
    assign oor  = {1'b0, req_q.wadr} >= DEPTH_W;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        dat_o_d = dat_o_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ready_q && (bus.hbus_rrq ^ bus.hbus_wrq)) begin
                    state_d    = LAT;
                    cnt_d      = LAT_INIT;
                    req_d.wadr = bus.hbus_adr_i[HBUS_ADDR_WIDTH-1:1];
                    req_d.dat  = bus.hbus_dat_i;
                    req_d.mask = bus.hbus_mask_i;
                    req_d.wr   = bus.hbus_wrq;
                end else if (ready_q && bus.hbus_rrq && bus.hbus_wrq) begin
                    err_d = 1'b1;
                end
            end
            LAT: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    mem_we  = req_q.wr && !oor;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (oor) begin
                    err_d = 1'b1;
                    if (!req_q.wr) begin
                        dat_o_d = '0;
                    end
                end else if (!req_q.wr) begin
                    valid_d = 1'b1;
                    dat_o_d = mem[widx];
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_comb begin
        wr_word = mem[widx];
        for (int b = 0; b < NB; b++) begin
            if (!req_q.mask[b]) begin
                wr_word[b*8 +: 8] = req_q.dat[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            dat_o_q <= dat_o_d;
        end
    end

    // Storage survives reset; a reset landing on the commit edge still suppresses the write.
    always_ff @(posedge hbus_clk) begin
        if (mem_we && !hbus_rst) begin
            mem[widx] <= wr_word;
        end
    end

    assign bus.hbus_ready = ready_q;
    assign bus.hbus_valid = valid_q;
    assign bus.hbus_err   = err_q;
    assign bus.hbus_dat_o = dat_o_q;
endmodule

// File: tb/tb_hyperbus_ram_responder.sv
// Bench for hyperbus_ram_responder: a LATENCY=4 and a LATENCY=1 instance checked against a timeline model,
// plus directed transactions with hand-computed expectations.
module tb_hyperbus_ram_responder;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hyperbus_ram_responder_if #(.HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16)) bus0 ();
    hyperbus_ram_responder_if #(.HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16)) bus1 ();

    hyperbus_ram_responder #(.HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16), .DEPTH(1024), .LATENCY(4)) u_dut0 (
        .hbus_clk(clk), .hbus_rst(rst), .bus(bus0)
    );
    hyperbus_ram_responder #(.HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16), .DEPTH(1024), .LATENCY(1)) u_dut1 (
        .hbus_clk(clk), .hbus_rst(rst), .bus(bus1)
    );

    logic [31:0] i_adr  [2];
    logic [15:0] i_dat  [2];
    logic [1:0]  i_mask [2];
    logic        i_rrq  [2];
    logic        i_wrq  [2];
    logic        o_rdy  [2];
    logic        o_vld  [2];
    logic        o_err  [2];
    logic [15:0] o_dat  [2];

    assign bus0.hbus_adr_i  = i_adr[0];
    assign bus0.hbus_dat_i  = i_dat[0];
    assign bus0.hbus_mask_i = i_mask[0];
    assign bus0.hbus_rrq    = i_rrq[0];
    assign bus0.hbus_wrq    = i_wrq[0];
    assign bus1.hbus_adr_i  = i_adr[1];
    assign bus1.hbus_dat_i  = i_dat[1];
    assign bus1.hbus_mask_i = i_mask[1];
    assign bus1.hbus_rrq    = i_rrq[1];
    assign bus1.hbus_wrq    = i_wrq[1];
    assign o_rdy[0] = bus0.hbus_ready;
    assign o_vld[0] = bus0.hbus_valid;
    assign o_err[0] = bus0.hbus_err;
    assign o_dat[0] = bus0.hbus_dat_o;
    assign o_rdy[1] = bus1.hbus_ready;
    assign o_vld[1] = bus1.hbus_valid;
    assign o_err[1] = bus1.hbus_err;
    assign o_dat[1] = bus1.hbus_dat_o;

    int tests = 0;
    int fails = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Model: a request accepted at edge a commits its write at edge a+L and shows its response after edge a+L+1.
    bit          m_ready [2];
    bit          m_valid [2];
    bit          m_err   [2];
    logic [15:0] m_dat   [2];
    bit          pend    [2];
    bit          p_wr    [2];
    int          left    [2];
    int unsigned p_idx   [2];
    logic [15:0] p_dat   [2];
    logic [1:0]  p_mask  [2];
    logic [15:0] m_mem   [2][1024];
    bit          rdy_b;

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ready[d] = 1'b0; m_valid[d] = 1'b0; m_err[d] = 1'b0;
            m_dat[d] = 16'h0; pend[d] = 1'b0; left[d] = 0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_ready[d] = 1'b0; m_valid[d] = 1'b0; m_err[d] = 1'b0;
                m_dat[d] = 16'h0; pend[d] = 1'b0;
            end else begin
                rdy_b = m_ready[d];
                m_valid[d] = 1'b0;
                m_err[d]   = 1'b0;
                if (pend[d]) begin
                    left[d] = left[d] - 1;
                    if (left[d] == 1 && p_wr[d] && p_idx[d] < 1024) begin
                        for (int b = 0; b < 2; b++)
                            if (!p_mask[d][b]) m_mem[d][p_idx[d]][b*8 +: 8] = p_dat[d][b*8 +: 8];
                    end
                    if (left[d] == 0) begin
                        pend[d] = 1'b0;
                        if (p_idx[d] >= 1024) begin
                            m_err[d] = 1'b1;
                            if (!p_wr[d]) m_dat[d] = 16'h0;
                        end else if (!p_wr[d]) begin
                            m_valid[d] = 1'b1;
                            m_dat[d]   = m_mem[d][p_idx[d]];
                        end
                    end
                end
                if (rdy_b && (i_rrq[d] ^ i_wrq[d])) begin
                    pend[d]   = 1'b1;
                    left[d]   = lat_of(d) + 1;
                    p_wr[d]   = i_wrq[d];
                    p_idx[d]  = i_adr[d] >> 1;
                    p_dat[d]  = i_dat[d];
                    p_mask[d] = i_mask[d];
                end else if (rdy_b && i_rrq[d] && i_wrq[d]) begin
                    m_err[d] = 1'b1;
                end
                m_ready[d] = !pend[d];
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            tests = tests + 4;
            if (o_rdy[d] !== (rst ? 1'b0 : m_ready[d])) begin
                fails++;
                $display("FAIL cmp_ready d%0d t=%0t: got %b expected %b", d, $time, o_rdy[d], rst ? 1'b0 : m_ready[d]);
            end
            if (o_vld[d] !== (rst ? 1'b0 : m_valid[d])) begin
                fails++;
                $display("FAIL cmp_valid d%0d t=%0t: got %b expected %b", d, $time, o_vld[d], rst ? 1'b0 : m_valid[d]);
            end
            if (o_err[d] !== (rst ? 1'b0 : m_err[d])) begin
                fails++;
                $display("FAIL cmp_err d%0d t=%0t: got %b expected %b", d, $time, o_err[d], rst ? 1'b0 : m_err[d]);
            end
            if (o_dat[d] !== (rst ? 16'h0 : m_dat[d])) begin
                fails++;
                $display("FAIL cmp_dat d%0d t=%0t: got %h expected %h", d, $time, o_dat[d], rst ? 16'h0 : m_dat[d]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request when ready, then watch 12 edges for pulses; lat is the edge of the first pulse.
    task automatic xact(input int d, input logic rd, input logic wr, input logic [31:0] adr,
                        input logic [15:0] dat, input logic [1:0] mask,
                        output int lat, output int nv, output int ne, output logic [15:0] rdat);
        for (int i = 0; i < 20 && o_rdy[d] !== 1'b1; i++) @(negedge clk);
        check("ready_wait", 32'(o_rdy[d]), 32'd1);
        i_adr[d] = adr; i_dat[d] = dat; i_mask[d] = mask; i_rrq[d] = rd; i_wrq[d] = wr;
        @(posedge clk);
        #1;
        i_rrq[d] = 1'b0; i_wrq[d] = 1'b0;
        i_adr[d] = 32'hFFFF_FFFF; i_dat[d] = 16'h5555; i_mask[d] = 2'b00;
        lat = 0; nv = 0; ne = 0; rdat = 16'h0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            if ((o_vld[d] || o_err[d]) && lat == 0) begin
                lat  = e;
                rdat = o_dat[d];
            end
            nv += int'(o_vld[d]);
            ne += int'(o_err[d]);
        end
    endtask

    int          lat, nv, ne, pulses, acc1, acc2, nacc;
    logic [15:0] rdat;
    logic        rdy_prev;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            i_adr[d] = 32'h0; i_dat[d] = 16'h0; i_mask[d] = 2'b00; i_rrq[d] = 1'b0; i_wrq[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(o_rdy[0]), 32'd0);
        check("reset_dat", 32'(o_dat[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(o_rdy[0]), 32'd1);

        xact(0, 1'b0, 1'b1, 32'h10, 16'hBEEF, 2'b00, lat, nv, ne, rdat);
        check("wr_beef_no_pulse", 32'(nv + ne), 32'd0);
        xact(0, 1'b1, 1'b0, 32'h10, 16'h0, 2'b00, lat, nv, ne, rdat);
        check("rd_beef_latency", 32'(lat), 32'd5);
        check("rd_beef_valid_count", 32'(nv), 32'd1);
        check("rd_beef_data", 32'(rdat), 32'hBEEF);

        xact(0, 1'b0, 1'b1, 32'h10, 16'h1234, 2'b01, lat, nv, ne, rdat);
        check("model_mem_0x10", 32'(m_mem[0][8]), 32'h12EF);
        xact(0, 1'b1, 1'b0, 32'h10, 16'h0, 2'b00, lat, nv, ne, rdat);
        check("rd_masked_data", 32'(rdat), 32'h12EF);
        xact(0, 1'b1, 1'b0, 32'h11, 16'h0, 2'b00, lat, nv, ne, rdat);
        check("rd_odd_addr_data", 32'(rdat), 32'h12EF);

        i_adr[0] = 32'h10; i_dat[0] = 16'h0000; i_mask[0] = 2'b00; i_rrq[0] = 1'b1; i_wrq[0] = 1'b1;
        @(posedge clk);
        #1 i_rrq[0] = 1'b0; i_wrq[0] = 1'b0;
        @(negedge clk);
        check("proto_err_ready", 32'(o_rdy[0]), 32'd1);
        check("proto_err_pulse", 32'(o_err[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("proto_err_single", 32'(o_err[0]), 32'd0);
        xact(0, 1'b1, 1'b0, 32'h10, 16'h0, 2'b00, lat, nv, ne, rdat);
        check("proto_err_storage", 32'(rdat), 32'h12EF);

        xact(0, 1'b1, 1'b0, 32'h800, 16'h0, 2'b00, lat, nv, ne, rdat);
        check("oor_rd_err_count", 32'(ne), 32'd1);
        check("oor_rd_valid_count", 32'(nv), 32'd0);
        check("oor_rd_data", 32'(rdat), 32'd0);
        check("oor_rd_latency", 32'(lat), 32'd5);

        xact(0, 1'b0, 1'b1, 32'h0, 16'h0F0F, 2'b00, lat, nv, ne, rdat);
        xact(0, 1'b0, 1'b1, 32'h800, 16'hFFFF, 2'b00, lat, nv, ne, rdat);
        check("oor_wr_err_count", 32'(ne), 32'd1);
        xact(0, 1'b1, 1'b0, 32'h0, 16'h0, 2'b00, lat, nv, ne, rdat);
        check("oor_wr_no_alias", 32'(rdat), 32'h0F0F);

        xact(0, 1'b0, 1'b1, 32'h7FE, 16'hC0DE, 2'b00, lat, nv, ne, rdat);
        xact(0, 1'b1, 1'b0, 32'h7FF, 16'h0, 2'b00, lat, nv, ne, rdat);
        check("top_word_data", 32'(rdat), 32'hC0DE);
        check("top_word_no_err", 32'(ne), 32'd0);

        // Reset lands in the second LAT cycle of a write that must never commit.
        xact(0, 1'b0, 1'b1, 32'h20, 16'h1111, 2'b00, lat, nv, ne, rdat);
        i_adr[0] = 32'h20; i_dat[0] = 16'hAAAA; i_mask[0] = 2'b00; i_wrq[0] = 1'b1;
        @(posedge clk);
        #1 i_wrq[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(o_vld[0]) + int'(o_err[0]);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_before_first_edge", 32'(o_rdy[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("ready_one_edge_after_release", 32'(o_rdy[0]), 32'd1);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            pulses += int'(o_vld[0]) + int'(o_err[0]);
        end
        check("reset_abandon_no_pulse", 32'(pulses), 32'd0);
        xact(0, 1'b1, 1'b0, 32'h20, 16'h0, 2'b00, lat, nv, ne, rdat);
        check("reset_abandon_storage", 32'(rdat), 32'h1111);

        xact(1, 1'b0, 1'b1, 32'h10, 16'h5A5A, 2'b00, lat, nv, ne, rdat);
        xact(1, 1'b1, 1'b0, 32'h10, 16'h0, 2'b00, lat, nv, ne, rdat);
        check("lat1_latency", 32'(lat), 32'd2);
        check("lat1_data", 32'(rdat), 32'h5A5A);

        // Read held asserted for four edges on the LATENCY=1 instance.
        i_adr[1] = 32'h10; i_rrq[1] = 1'b1;
        acc1 = -1; acc2 = -1; nacc = 0; nv = 0;
        for (int e = 1; e <= 9; e++) begin
            if (e == 5) i_rrq[1] = 1'b0;
            rdy_prev = o_rdy[1];
            @(posedge clk);
            if (rdy_prev && i_rrq[1]) begin
                nacc++;
                if (acc1 < 0) acc1 = e;
                else if (acc2 < 0) acc2 = e;
            end
            @(negedge clk);
            nv += int'(o_vld[1]);
        end
        check("b2b_accept_count", 32'(nacc), 32'd2);
        check("b2b_accept_spacing", 32'(acc2 - acc1), 32'd3);
        check("b2b_valid_count", 32'(nv), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end
endmodule
